// File: rtl/edf_arbiter.sv
// Earliest-deadline-first selector: scans one source per cycle and publishes the
// enabled pending source with the smallest deadline, with a claim/clear handshake.
//
// state  | meaning
// -------+-----------------------------------------------------------
// SCAN   | evaluate source idx against the running best, idx 0..NrSrc-1
// COMMIT | copy running best into the published registers, restart scan
module edf_arbiter #(
  parameter int unsigned NrSrc   = 8,
  parameter int unsigned TsWidth = 64,
  parameter int unsigned IdWidth = $clog2(NrSrc)
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NrSrc-1:0][TsWidth-1:0]   dl_i,
  input  logic [NrSrc-1:0]                ip_i,
  input  logic [NrSrc-1:0]                ie_i,
  input  logic                            claim_i,
  output logic                            irq_o,
  output logic [IdWidth-1:0]              id_o,
  output logic [TsWidth-1:0]              dl_o,
  output logic [NrSrc-1:0]                clr_o
);

  typedef enum logic {SCAN, COMMIT} state_e;

  localparam logic [IdWidth-1:0] LastIdx = IdWidth'(NrSrc - 1);

  state_e               state_q, state_d;
  logic [IdWidth-1:0]   idx_q, idx_d;
  logic                 found_q, found_d;
  logic [IdWidth-1:0]   best_id_q, best_id_d;
  logic [TsWidth-1:0]   best_dl_q, best_dl_d;
  logic                 pub_valid_q, pub_valid_d;
  logic [IdWidth-1:0]   pub_id_q, pub_id_d;
  logic [TsWidth-1:0]   pub_dl_q, pub_dl_d;
  logic [NrSrc-1:0]     clr_q, clr_d;

  logic                 cand;
  logic                 take;
  logic                 claim_ok;

  // The published source is re-qualified every cycle so a dropped pending or
  // enable hides it immediately rather than at the next commit.
  assign irq_o    = pub_valid_q & ip_i[pub_id_q] & ie_i[pub_id_q];
  assign claim_ok = claim_i & irq_o;
  assign cand     = ip_i[idx_q] & ie_i[idx_q];
  assign take     = cand & (~found_q | (dl_i[idx_q] < best_dl_q));

  assign id_o  = pub_id_q;
  assign dl_o  = pub_dl_q;
  assign clr_o = clr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= SCAN;
      idx_q       <= '0;
      found_q     <= 1'b0;
      best_id_q   <= '0;
      best_dl_q   <= '0;
      pub_valid_q <= 1'b0;
      pub_id_q    <= '0;
      pub_dl_q    <= '0;
      clr_q       <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      found_q     <= found_d;
      best_id_q   <= best_id_d;
      best_dl_q   <= best_dl_d;
      pub_valid_q <= pub_valid_d;
      pub_id_q    <= pub_id_d;
      pub_dl_q    <= pub_dl_d;
      clr_q       <= clr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    found_d     = found_q;
    best_id_d   = best_id_q;
    best_dl_d   = best_dl_q;
    pub_valid_d = pub_valid_q;
    pub_id_d    = pub_id_q;
    pub_dl_d    = pub_dl_q;
    clr_d       = '0;

    if (claim_ok) begin
      // A claim wins over a coinciding commit and restarts the scan from scratch.
      pub_valid_d = 1'b0;
      clr_d       = NrSrc'(1) << pub_id_q;
      state_d     = SCAN;
      idx_d       = '0;
      found_d     = 1'b0;
      best_id_d   = '0;
      best_dl_d   = '0;
    end else begin
      case (state_q)
        SCAN: begin
          if (take) begin
            found_d   = 1'b1;
            best_id_d = idx_q;
            best_dl_d = dl_i[idx_q];
          end
          if (idx_q == LastIdx) begin
            state_d = COMMIT;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        COMMIT: begin
          pub_valid_d = found_q;
          if (found_q) begin
            pub_id_d = best_id_q;
            pub_dl_d = best_dl_q;
          end
          found_d   = 1'b0;
          best_id_d = '0;
          best_dl_d = '0;
          state_d   = SCAN;
          idx_d     = '0;
        end
        default: begin
          state_d = SCAN;
          idx_d   = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_edf_arbiter.sv
// Directed self-checking bench for edf_arbiter with four sources and 64-bit deadlines.
module tb_edf_arbiter;

  localparam int NrSrc   = 4;
  localparam int TsWidth = 64;
  localparam int IdWidth = 2;

  logic                          clk_i;
  logic                          rst_ni;
  logic [NrSrc-1:0][TsWidth-1:0] dl_i;
  logic [NrSrc-1:0]              ip_i;
  logic [NrSrc-1:0]              ie_i;
  logic                          claim_i;
  logic                          irq_o;
  logic [IdWidth-1:0]            id_o;
  logic [TsWidth-1:0]            dl_o;
  logic [NrSrc-1:0]              clr_o;

  int checks = 0;
  int errors = 0;

  edf_arbiter #(.NrSrc(NrSrc), .TsWidth(TsWidth)) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .dl_i    (dl_i),
    .ip_i    (ip_i),
    .ie_i    (ie_i),
    .claim_i (claim_i),
    .irq_o   (irq_o),
    .id_o    (id_o),
    .dl_o    (dl_o),
    .clr_o   (clr_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_dl(input logic [63:0] d3, input logic [63:0] d2,
                        input logic [63:0] d1, input logic [63:0] d0);
    dl_i[3] = d3;
    dl_i[2] = d2;
    dl_i[1] = d1;
    dl_i[0] = d0;
  endtask

  // Reset released just after a rising edge so the next edge scans index 0.
  task automatic apply_reset();
    @(posedge clk_i);
    #1;
    rst_ni = 1'b0;
    #2;
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    rst_ni  = 1'b0;
    claim_i = 1'b0;
    ip_i    = 4'b1111;
    ie_i    = 4'b1111;
    set_dl(64'd400, 64'd100, 64'd300, 64'd200);
    #2;
    checks++;
    if ({irq_o, id_o, dl_o, clr_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: irq=%b id=%0d dl=%0d clr=%b, required all 0", irq_o, id_o, dl_o, clr_o);
    end
    tick();
    tick();
    checks++;
    if ({irq_o, clr_o} !== 5'b0) begin
      errors++;
      $display("FAIL reset_held: irq=%b clr=%b, required 0", irq_o, clr_o);
    end
    rst_ni = 1'b1;
  endtask

  task automatic test_basic();
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (irq_o !== 1'b0) begin
      errors++;
      $display("FAIL basic_before_commit: irq=%b, required 0", irq_o);
    end
    tick();
    checks++;
    if (irq_o !== 1'b1 || id_o !== 2'd2 || dl_o !== 64'd100) begin
      errors++;
      $display("FAIL basic_select: irq=%b id=%0d dl=%0d, required 1/2/100", irq_o, id_o, dl_o);
    end
  endtask

  task automatic test_claim();
    claim_i = 1'b1;
    tick();
    claim_i = 1'b0;
    ip_i    = 4'b1011;
    checks++;
    if (clr_o !== 4'b0100 || irq_o !== 1'b0) begin
      errors++;
      $display("FAIL claim_pulse: clr=%b irq=%b, required 0100/0", clr_o, irq_o);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (clr_o !== 4'b0000 || irq_o !== 1'b0) begin
        errors++;
        $display("FAIL claim_quiet[%0d]: clr=%b irq=%b, required 0000/0", i, clr_o, irq_o);
      end
    end
    tick();
    checks++;
    if (irq_o !== 1'b1 || id_o !== 2'd0 || dl_o !== 64'd200) begin
      errors++;
      $display("FAIL claim_republish: irq=%b id=%0d dl=%0d, required 1/0/200", irq_o, id_o, dl_o);
    end
  endtask

  task automatic test_tie_mask();
    ip_i = 4'b1111;
    ie_i = 4'b1110;
    set_dl(64'd50, 64'd50, 64'd50, 64'd50);
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (irq_o !== 1'b1 || id_o !== 2'd1 || dl_o !== 64'd50) begin
      errors++;
      $display("FAIL tie_break: irq=%b id=%0d dl=%0d, required 1/1/50", irq_o, id_o, dl_o);
    end
    ie_i = 4'b0000;
    #1;
    checks++;
    if (irq_o !== 1'b0) begin
      errors++;
      $display("FAIL mask_comb: irq=%b, required 0", irq_o);
    end
    for (int i = 0; i < 5; i++) tick();
    ie_i = 4'b1111;
    #1;
    checks++;
    if (irq_o !== 1'b0 || id_o !== 2'd1 || dl_o !== 64'd50) begin
      errors++;
      $display("FAIL mask_commit_clear: irq=%b id=%0d dl=%0d, required 0/1/50", irq_o, id_o, dl_o);
    end
  endtask

  task automatic test_ignored_claim();
    int bad = 0;
    ip_i    = 4'b0000;
    claim_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (clr_o !== 4'b0000 || irq_o !== 1'b0) begin
        errors++;
        bad++;
        if (bad < 4) $display("FAIL ignored_claim[%0d]: clr=%b irq=%b, required 0000/0", i, clr_o, irq_o);
      end
    end
    claim_i = 1'b0;
  endtask

  task automatic test_late_pending();
    ip_i = 4'b0011;
    ie_i = 4'b1111;
    set_dl(64'd0, 64'd0, 64'd300, 64'd200);
    apply_reset();
    for (int i = 0; i < 4; i++) tick();
    ip_i    = 4'b1011;
    dl_i[3] = 64'd10;
    tick();
    checks++;
    if (irq_o !== 1'b1 || id_o !== 2'd0 || dl_o !== 64'd200) begin
      errors++;
      $display("FAIL late_first_commit: irq=%b id=%0d dl=%0d, required 1/0/200", irq_o, id_o, dl_o);
    end
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (irq_o !== 1'b1 || id_o !== 2'd3 || dl_o !== 64'd10) begin
      errors++;
      $display("FAIL late_second_commit: irq=%b id=%0d dl=%0d, required 1/3/10", irq_o, id_o, dl_o);
    end
    ip_i[3] = 1'b0;
    #1;
    checks++;
    if (irq_o !== 1'b0) begin
      errors++;
      $display("FAIL stale_winner: irq=%b, required 0", irq_o);
    end
  endtask

  task automatic test_reset_mid();
    ip_i = 4'b1111;
    ie_i = 4'b1111;
    set_dl(64'd400, 64'd100, 64'd300, 64'd200);
    apply_reset();
    for (int i = 0; i < 7; i++) tick();
    rst_ni = 1'b0;
    #1;
    checks++;
    if ({irq_o, id_o, dl_o, clr_o} !== '0) begin
      errors++;
      $display("FAIL reset_mid_scan: irq=%b id=%0d dl=%0d clr=%b, required all 0", irq_o, id_o, dl_o, clr_o);
    end
    rst_ni = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    claim_i = 1'b1;
    tick();
    claim_i = 1'b0;
    checks++;
    if (clr_o !== 4'b0100) begin
      errors++;
      $display("FAIL reset_pre_pulse: clr=%b, required 0100", clr_o);
    end
    rst_ni = 1'b0;
    #1;
    checks++;
    if ({irq_o, id_o, dl_o, clr_o} !== '0) begin
      errors++;
      $display("FAIL reset_mid_claim: irq=%b id=%0d dl=%0d clr=%b, required all 0", irq_o, id_o, dl_o, clr_o);
    end
    rst_ni = 1'b1;
    tick();
    checks++;
    if (clr_o !== 4'b0000 || irq_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_after_release: clr=%b irq=%b, required 0000/0", clr_o, irq_o);
    end
  endtask

  task automatic test_width_extremes();
    ip_i = 4'b1111;
    ie_i = 4'b1111;
    set_dl(64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF,
           64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    apply_reset();
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (irq_o !== 1'b1 || id_o !== 2'd3 || dl_o !== 64'hFFFF_FFFF_FFFF_FFFE) begin
      errors++;
      $display("FAIL width_idx3: irq=%b id=%0d dl=%h, required 1/3/fffffffffffffffe", irq_o, id_o, dl_o);
    end
    set_dl(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
           64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF);
    apply_reset();
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (irq_o !== 1'b1 || id_o !== 2'd1 || dl_o !== 64'hFFFF_FFFF_FFFF_FFFE) begin
      errors++;
      $display("FAIL width_idx1: irq=%b id=%0d dl=%h, required 1/1/fffffffffffffffe", irq_o, id_o, dl_o);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_claim();
    test_tie_mask();
    test_ignored_claim();
    test_late_pending();
    test_reset_mid();
    test_width_extremes();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
